// File: rtl/pc_fetch_stage_pkg.sv
// Shared widths, reset vector and FSM encoding for the instruction fetch stage.
// Also holds the sequential-PC helper used by the fetch stage.
package pc_fetch_stage_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned INST_W = 32;

   localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
   localparam logic [ADDR_W-1:0] PC_STEP          = 32'h0000_0004;

   // REQ: ROM request outstanding, HOLD: word buffered while ID stalls,
   // DROP: waiting to swallow a response that a flush made stale.
   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_HOLD = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_e;

   // Next sequential fetch address; wraps modulo 2^32.
   function automatic logic [ADDR_W-1:0] seq_pc(input logic [ADDR_W-1:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/pc_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush clears valid, load captures a new word,
// hold freezes the contents, otherwise a bubble is inserted.
module pc_fetch_stage_if_id_reg
   import pc_fetch_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic              i_load,
   input  logic              i_hold,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [INST_W-1:0] i_inst,
   output logic [ADDR_W-1:0] o_addr,
   output logic [INST_W-1:0] o_inst,
   output logic              o_valid
);

   logic [ADDR_W-1:0] r_addr;
   logic [INST_W-1:0] r_inst;
   logic              r_valid;

   // Flush outranks load and hold; data fields are left alone when invalidated.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= 32'h0000_0000;
         r_inst  <= 32'h0000_0000;
         r_valid <= 1'b0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_addr  <= i_addr;
         r_inst  <= i_inst;
         r_valid <= 1'b1;
      end else if (!i_hold) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_valid;
      end
   end

   assign o_addr  = r_addr;
   assign o_inst  = r_inst;
   assign o_valid = r_valid;

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: PC generation, ROM handshake FSM, branch delay-slot
// redirect tracking and flush handling, feeding the IF/ID register.
module pc_fetch_stage
   import pc_fetch_stage_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_id,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_pc,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_addr,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic              rom_ready,
   input  logic [INST_W-1:0] rom_rdata,
   output logic [ADDR_W-1:0] id_addr,
   output logic [INST_W-1:0] id_inst,
   output logic              id_valid,
   output logic              fetch_stall
);

   fetch_state_e      r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [INST_W-1:0] r_buf;
   logic              r_redir_pending;
   logic [ADDR_W-1:0] r_redir_addr;

   fetch_state_e      w_state_nxt;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [INST_W-1:0] w_buf_nxt;
   logic              w_redir_pending_nxt;
   logic [ADDR_W-1:0] w_redir_addr_nxt;

   logic              w_in_req;
   logic              w_in_hold;
   logic              w_in_drop;
   logic              w_deliver;
   logic              w_branch_taken;
   logic [INST_W-1:0] w_word;

   assign w_in_req       = (r_state == ST_REQ);
   assign w_in_hold      = (r_state == ST_HOLD);
   assign w_in_drop      = (r_state == ST_DROP);
   assign w_deliver      = ((w_in_req && rom_ready) || w_in_hold) && !stall_id && !flush;
   assign w_branch_taken = branch_flag && id_valid && !stall_id;
   assign w_word         = w_in_hold ? r_buf : rom_rdata;

   // Next-state, next-PC and redirect bookkeeping.
   always_comb begin
      w_state_nxt         = r_state;
      w_pc_nxt            = r_pc;
      w_buf_nxt           = r_buf;
      w_redir_pending_nxt = r_redir_pending;
      w_redir_addr_nxt    = r_redir_addr;

      case (r_state)
         ST_REQ: begin
            if (flush) begin
               w_state_nxt = rom_ready ? ST_REQ : ST_DROP;
            end else if (rom_ready && stall_id) begin
               w_state_nxt = ST_HOLD;
               w_buf_nxt   = rom_rdata;
            end else begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_HOLD: begin
            if (flush || w_deliver) begin
               w_state_nxt = ST_REQ;
            end else begin
               w_state_nxt = ST_HOLD;
            end
         end
         ST_DROP: begin
            if (rom_ready) begin
               w_state_nxt = ST_REQ;
            end else begin
               w_state_nxt = ST_DROP;
            end
         end
         default: begin
            w_state_nxt = ST_REQ;
         end
      endcase

      // A branch seen without a delivery is remembered so the delay slot still goes out first.
      if (flush) begin
         w_pc_nxt            = flush_pc;
         w_redir_pending_nxt = 1'b0;
      end else if (w_deliver) begin
         if (w_branch_taken) begin
            w_pc_nxt = branch_addr;
         end else if (r_redir_pending) begin
            w_pc_nxt = r_redir_addr;
         end else begin
            w_pc_nxt = seq_pc(r_pc);
         end
         w_redir_pending_nxt = 1'b0;
      end else if (w_branch_taken) begin
         w_redir_pending_nxt = 1'b1;
         w_redir_addr_nxt    = branch_addr;
      end else begin
         w_redir_pending_nxt = r_redir_pending;
      end
   end

   // State register; reset abandons any outstanding request outright.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_REQ;
         r_pc            <= RESET_PC;
         r_buf           <= 32'h0000_0000;
         r_redir_pending <= 1'b0;
         r_redir_addr    <= 32'h0000_0000;
      end else begin
         r_state         <= w_state_nxt;
         r_pc            <= w_pc_nxt;
         r_buf           <= w_buf_nxt;
         r_redir_pending <= w_redir_pending_nxt;
         r_redir_addr    <= w_redir_addr_nxt;
      end
   end

   pc_fetch_stage_if_id_reg u_if_id (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_load  (w_deliver),
      .i_hold  (stall_id),
      .i_addr  (r_pc),
      .i_inst  (w_word),
      .o_addr  (id_addr),
      .o_inst  (id_inst),
      .o_valid (id_valid)
   );

   assign rom_en      = w_in_req;
   assign rom_addr    = r_pc;
   assign fetch_stall = (w_in_req && !rom_ready) || w_in_drop;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed testbench for pc_fetch_stage; the ROM returns addr ^ KEY as data.
module tb_pc_fetch_stage;

   localparam logic [31:0] KEY = 32'h1234_5678;

   logic        clk;
   logic        rst;
   logic        stall_id;
   logic        flush;
   logic [31:0] flush_pc;
   logic        branch_flag;
   logic [31:0] branch_addr;
   logic        rom_en;
   logic [31:0] rom_addr;
   logic        rom_ready;
   logic [31:0] rom_rdata;
   logic [31:0] id_addr;
   logic [31:0] id_inst;
   logic        id_valid;
   logic        fetch_stall;

   int n_checks;
   int n_fail;

   pc_fetch_stage dut (
      .clk         (clk),
      .rst         (rst),
      .stall_id    (stall_id),
      .flush       (flush),
      .flush_pc    (flush_pc),
      .branch_flag (branch_flag),
      .branch_addr (branch_addr),
      .rom_en      (rom_en),
      .rom_addr    (rom_addr),
      .rom_ready   (rom_ready),
      .rom_rdata   (rom_rdata),
      .id_addr     (id_addr),
      .id_inst     (id_inst),
      .id_valid    (id_valid),
      .fetch_stall (fetch_stall)
   );

   assign rom_rdata = rom_addr ^ KEY;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ KEY;
   endfunction

   // Inputs set before tick() are applied at that edge; returns 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; stall_id = 1'b0; flush = 1'b0; flush_pc = 32'h0;
      branch_flag = 1'b0; branch_addr = 32'h0; rom_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic stream(input int n);
      rom_ready = 1'b1;
      repeat (n) tick();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", id_valid); end
      n_checks++; if (id_addr !== 32'h0) begin n_fail++; $display("FAIL reset_id_addr got %h want 0", id_addr); end
      n_checks++; if (id_inst !== 32'h0) begin n_fail++; $display("FAIL reset_id_inst got %h want 0", id_inst); end
      n_checks++; if (rom_en !== 1'b1) begin n_fail++; $display("FAIL reset_rom_en got %b want 1", rom_en); end
      n_checks++; if (rom_addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL reset_rom_addr got %h want bfc00000", rom_addr); end
      n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_noready got %b want 1", fetch_stall); end
      rom_ready = 1'b1; #1;
      n_checks++; if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_ready got %b want 0", fetch_stall); end
      // reset taken while in DROP must return straight to REQ at the reset vector
      rom_ready = 1'b0; flush = 1'b1; flush_pc = 32'hBFC0_0380;
      tick();
      n_checks++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL reset_drop_entry got %b want 0", rom_en); end
      rst = 1'b1; tick();
      rst = 1'b0; flush = 1'b0; #1;
      n_checks++; if (rom_en !== 1'b1 || rom_addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL reset_mid_drop got en=%b addr=%h want 1 bfc00000", rom_en, rom_addr); end
      rom_ready = 1'b1; tick();
      n_checks++; if (id_valid !== 1'b1 || id_addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL reset_no_drop got v=%b addr=%h want 1 bfc00000", id_valid, id_addr); end
   endtask

   task automatic test_stream();
      logic [31:0] exp;
      do_reset();
      rom_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp = 32'hBFC0_0000 + 32'(i * 4);
         tick();
         n_checks++; if (id_valid !== 1'b1 || id_addr !== exp || id_inst !== word(exp)) begin
            n_fail++; $display("FAIL stream_%0d got v=%b addr=%h inst=%h want 1 %h %h", i, id_valid, id_addr, id_inst, exp, word(exp));
         end
      end
   endtask

   task automatic test_latency();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         rom_ready = (i == 2) ? 1'b1 : 1'b0;
         #1;
         n_checks++; if (rom_addr !== 32'hBFC0_0000 || rom_en !== 1'b1) begin n_fail++; $display("FAIL lat_addr_%0d got en=%b addr=%h want 1 bfc00000", i, rom_en, rom_addr); end
         n_checks++; if (fetch_stall !== (i != 2)) begin n_fail++; $display("FAIL lat_stall_%0d got %b want %b", i, fetch_stall, (i != 2)); end
         tick();
         n_checks++; if (id_valid !== (i == 2)) begin n_fail++; $display("FAIL lat_valid_%0d got %b want %b", i, id_valid, (i == 2)); end
      end
      n_checks++; if (id_addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL lat_id_addr got %h want bfc00000", id_addr); end
      n_checks++; if (rom_addr !== 32'hBFC0_0004) begin n_fail++; $display("FAIL lat_next_addr got %h want bfc00004", rom_addr); end
   endtask

   task automatic test_branch();
      do_reset();
      stream(5);
      n_checks++; if (id_addr !== 32'hBFC0_0010 || id_valid !== 1'b1) begin n_fail++; $display("FAIL br_setup got v=%b addr=%h want 1 bfc00010", id_valid, id_addr); end
      rom_ready = 1'b0; branch_flag = 1'b1; branch_addr = 32'hBFC0_0100;
      tick();
      branch_flag = 1'b0;
      n_checks++; if (id_valid !== 1'b0 || rom_addr !== 32'hBFC0_0014) begin n_fail++; $display("FAIL br_wait got v=%b addr=%h want 0 bfc00014", id_valid, rom_addr); end
      rom_ready = 1'b1; tick();
      n_checks++; if (id_valid !== 1'b1 || id_addr !== 32'hBFC0_0014 || id_inst !== word(32'hBFC0_0014)) begin n_fail++; $display("FAIL br_delay_slot got v=%b addr=%h inst=%h want 1 bfc00014", id_valid, id_addr, id_inst); end
      n_checks++; if (rom_addr !== 32'hBFC0_0100) begin n_fail++; $display("FAIL br_target got %h want bfc00100", rom_addr); end
      tick();
      n_checks++; if (id_addr !== 32'hBFC0_0100) begin n_fail++; $display("FAIL br_target_deliv got %h want bfc00100", id_addr); end
   endtask

   task automatic test_hold();
      do_reset();
      stream(8);
      stall_id = 1'b1; rom_ready = 1'b1; #1;
      n_checks++; if (rom_addr !== 32'hBFC0_0020 || fetch_stall !== 1'b0) begin n_fail++; $display("FAIL hold_req got addr=%h st=%b want bfc00020 0", rom_addr, fetch_stall); end
      tick();
      rom_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (rom_en !== 1'b0 || fetch_stall !== 1'b0) begin n_fail++; $display("FAIL hold_rom_%0d got en=%b st=%b want 0 0", i, rom_en, fetch_stall); end
         n_checks++; if (id_valid !== 1'b1 || id_addr !== 32'hBFC0_001C) begin n_fail++; $display("FAIL hold_frozen_%0d got v=%b addr=%h want 1 bfc0001c", i, id_valid, id_addr); end
         tick();
      end
      stall_id = 1'b0; tick();
      n_checks++; if (id_valid !== 1'b1 || id_addr !== 32'hBFC0_0020 || id_inst !== word(32'hBFC0_0020)) begin n_fail++; $display("FAIL hold_release got v=%b addr=%h inst=%h want 1 bfc00020", id_valid, id_addr, id_inst); end
      n_checks++; if (rom_en !== 1'b1 || rom_addr !== 32'hBFC0_0024) begin n_fail++; $display("FAIL hold_resume got en=%b addr=%h want 1 bfc00024", rom_en, rom_addr); end
      rom_ready = 1'b1; tick();
      n_checks++; if (id_addr !== 32'hBFC0_0024) begin n_fail++; $display("FAIL hold_no_dup got %h want bfc00024", id_addr); end
   endtask

   task automatic test_flush();
      do_reset();
      stream(5);
      rom_ready = 1'b0; branch_flag = 1'b1; branch_addr = 32'hBFC0_0100;
      tick();
      branch_flag = 1'b0; flush = 1'b1; flush_pc = 32'hBFC0_0380;
      tick();
      flush = 1'b0; #1;
      n_checks++; if (rom_en !== 1'b0 || fetch_stall !== 1'b1 || id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop got en=%b st=%b v=%b want 0 1 0", rom_en, fetch_stall, id_valid); end
      rom_ready = 1'b1; tick();
      n_checks++; if (id_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 32'hBFC0_0380) begin n_fail++; $display("FAIL flush_discard got v=%b en=%b addr=%h want 0 1 bfc00380", id_valid, rom_en, rom_addr); end
      tick();
      n_checks++; if (id_valid !== 1'b1 || id_addr !== 32'hBFC0_0380 || id_inst !== word(32'hBFC0_0380)) begin n_fail++; $display("FAIL flush_target got v=%b addr=%h want 1 bfc00380", id_valid, id_addr); end
      n_checks++; if (rom_addr !== 32'hBFC0_0384) begin n_fail++; $display("FAIL flush_cancel_branch got %h want bfc00384", rom_addr); end
   endtask

   task automatic test_flush_branch();
      do_reset();
      stream(5);
      flush = 1'b1; flush_pc = 32'hBFC0_0380; branch_flag = 1'b1; branch_addr = 32'hBFC0_0100; rom_ready = 1'b1;
      tick();
      flush = 1'b0; branch_flag = 1'b0;
      n_checks++; if (id_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 32'hBFC0_0380) begin n_fail++; $display("FAIL fb_redirect got v=%b en=%b addr=%h want 0 1 bfc00380", id_valid, rom_en, rom_addr); end
      tick();
      n_checks++; if (id_addr !== 32'hBFC0_0380 || rom_addr !== 32'hBFC0_0384) begin n_fail++; $display("FAIL fb_resume got id=%h rom=%h want bfc00380 bfc00384", id_addr, rom_addr); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      stream(5);
      branch_flag = 1'b1; branch_addr = 32'hBFC0_0100;
      tick();
      branch_flag = 1'b0;
      n_checks++; if (id_addr !== 32'hBFC0_0014 || rom_addr !== 32'hBFC0_0100) begin n_fail++; $display("FAIL b2b_branch got id=%h rom=%h want bfc00014 bfc00100", id_addr, rom_addr); end
      tick();
      n_checks++; if (id_addr !== 32'hBFC0_0100 || id_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_target got v=%b id=%h want 1 bfc00100", id_valid, id_addr); end
      flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
      tick();
      flush = 1'b0; tick();
      n_checks++; if (id_addr !== 32'hFFFF_FFFC || rom_addr !== 32'h0000_0000) begin n_fail++; $display("FAIL b2b_wrap got id=%h rom=%h want fffffffc 00000000", id_addr, rom_addr); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_stream();
      test_latency();
      test_branch();
      test_hold();
      test_flush();
      test_flush_branch();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 SHALL expose: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL expose: rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL expose: stall_id  in  1  ID stage cannot accept; IF/ID register holds.
REQ-004 SHALL expose: flush  in  1  exception/eret redirect; discard all in-flight fetch state.
REQ-005 SHALL expose: flush_pc  in  32  redirect target, valid with flush.
REQ-006 SHALL expose: branch_flag  in  1 / branch_addr  in  32  from ID branch logic, combinational on ID contents.
REQ-007 SHALL expose: rom_en  out  1 / rom_addr  out  32  instruction-ROM request.
REQ-008 SHALL expose: rom_ready  in  1 / rom_rdata  in  32  ROM response, data valid in the cycle ready=1.
REQ-009 SHALL expose: id_addr  out  32 / id_inst  out  32 / id_valid  out  1  IF/ID pipeline register.
REQ-010 SHALL expose: fetch_stall  out  1  high while a request is outstanding or in DROP.
REQ-011 SHALL expose parameter RESET_PC, default 32'hBFC0_0000, first fetch address.

Function
REQ-012 SHALL implement states REQ (request outstanding), HOLD (word buffered, ID stalled), DROP (discard stale response).
REQ-013 In REQ, rom_en=1 and rom_addr=pc, held stable until rom_ready.
REQ-014 Deliver event = (REQ & rom_ready | HOLD) & !stall_id & !flush; on deliver, IF/ID <= {pc, word}, id_valid <= 1.
REQ-015 REQ & rom_ready & stall_id SHALL buffer rom_rdata and enter HOLD with rom_en=0; HOLD -> REQ on deliver.
REQ-016 pc SHALL change only on deliver or flush; on deliver next pc = branch_addr if branch taken this cycle, else pending target if redir_pending, else pc+4 (mod 2^32).
REQ-017 Branch taken this cycle = branch_flag & id_valid & !stall_id; if no deliver that cycle, latch redir_pending=1, redir_addr=branch_addr.
REQ-018 redir_pending SHALL clear on the deliver that consumes it; the delivered word is the delay slot and is never dropped.
REQ-019 No deliver & !stall_id SHALL load id_valid <= 0 (bubble); stall_id SHALL hold id_addr/id_inst/id_valid unchanged.
REQ-020 flush SHALL win over all other events: pc <= flush_pc, id_valid <= 0, redir_pending <= 0, HOLD buffer discarded.
REQ-021 flush in REQ without rom_ready SHALL enter DROP (rom_en=0); DROP -> REQ on rom_ready, response discarded.
REQ-022 flush in REQ with rom_ready, in HOLD, or in DROP with rom_ready SHALL go directly to REQ at flush_pc.
REQ-023 fetch_stall = (REQ & !rom_ready) | DROP.

Reset
REQ-024 rst SHALL set state=REQ, pc=RESET_PC, id_valid=0, id_addr=0, id_inst=0, redir_pending=0, redir_addr=0.
REQ-025 rst SHALL take priority over flush and all inputs; reset mid-fetch abandons the outstanding request without DROP.
REQ-026 Outputs after reset: rom_en=1, rom_addr=RESET_PC, fetch_stall=!rom_ready.

Structure
REQ-027 RESET_PC, 32-bit address/instruction widths and state encodings SHALL live in the shared bus/constants headers.
REQ-028 IF/ID register MAY be sub-module if_id_reg (load, hold, clear); PC/FSM logic SHALL be in pc_fetch_stage.

Verification
REQ-029 Reset, rom_ready=1 always -> id_addr 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles, id_valid=1 from cycle 2.
REQ-030 rom_ready 3-cycle latency -> rom_addr stable 3 cycles, fetch_stall=1 for 2, two bubbles (id_valid=0) then one delivery.
REQ-031 Branch at 0xBFC00010 to 0xBFC00100, ROM 2-cycle latency -> delay slot 0xBFC00014 delivered, next fetch 0xBFC00100.
REQ-032 stall_id high 4 cycles while word 0xBFC00020 returns -> HOLD, rom_en=0, id_* frozen; word delivered on release, no loss/duplication.
REQ-033 flush (flush_pc=0xBFC00380) with fetch outstanding -> DROP, stale word discarded, next id_addr 0xBFC00380, pending branch cancelled.
REQ-034 flush and branch_flag same cycle as rom_ready -> fetch resumes at 0xBFC00380, branch target ignored, id_valid=0.
